serial_word_collector: RTL
==========================

Name: serial_word_collector

Overview:
- Serial-to-parallel collector downstream of the multi-mode shifter.
- Consumes the shifter's s_out bit stream, qualified by a per-bit strobe, and assembles WIDTH-bit words in MSB-first or LSB-first order.
- Hands each completed word to the next stage over a valid/ready handshake, through a single holding register.
- Supports frame realignment and sticky overrun detection.

Parameters:
- WIDTH, 8, word width in bits; legal range is WIDTH >= 2.
- CW, $clog2(WIDTH), width of the bit counter; derived, not overridden.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- bit_valid  in  1  bit_in is accepted this cycle.
- bit_in  in  1  serial data bit, from the shifter's s_out.
- msb_first  in  1  1 = first bit received is word MSB; 0 = first bit is LSB.
- sync_clear  in  1  discard the partial word and realign the frame.
- word_ready  in  1  downstream accepts word_data this cycle.
- clr_overrun  in  1  clears the overrun flag.
- word_data  out  WIDTH  completed word (holding register).
- word_valid  out  1  word_data holds an unconsumed word.
- overrun  out  1  sticky flag: a completed word was dropped.
- bit_count  out  CW  number of bits collected in the current partial word.

Behaviour:
- Reset: shift register, word_data, word_valid, overrun, bit_count and the latched order bit all go to 0. Reset overrides every other input.
- Order latch: msb_first is sampled only when a bit is accepted with bit_count==0. Changes mid-word have no effect until the next word.
- Shifting, on each accepted bit:
  - MSB-first: sh <= {sh[WIDTH-2:0], bit_in}.
  - LSB-first: sh <= {bit_in, sh[WIDTH-1:1]}.
  - bit_count increments by 1.
- Completion: the WIDTH-th accepted bit (bit_count==WIDTH-1 with bit_valid) wraps bit_count to 0. The fully shifted value, including that bit, is the completed word.
- Latency: word_valid=1 and word_data=completed word in the cycle after the last bit is accepted. Collection of the next word continues with no gap; back-to-back bit_valid is legal indefinitely.
- Handshake: a transfer occurs when word_valid & word_ready. word_data is stable while word_valid=1 and no transfer has occurred. After a transfer with no new completion, word_valid falls to 0 next cycle; word_data keeps its last value.
- Simultaneous transfer + completion: the new word loads, word_valid stays 1, no overrun.
- Completion while word_valid=1 and word_ready=0: the new word is dropped. word_data is unchanged and overrun <= 1.
- overrun is sticky until clr_overrun.
  - clr_overrun together with a new overrun event: set wins, overrun stays 1.
  - word_ready has no effect on overrun.
- sync_clear:
  - Without bit_valid: bit_count <= 0 and the partial bits are discarded.
  - With bit_valid in the same cycle: the bit becomes bit 0 of a new word (bit_count <= 1) and the order is re-latched from msb_first.
  - Never affects word_data, word_valid or overrun.
  - If sync_clear arrives on the completing bit, the completion is cancelled.
- Shift register contents are don't-care outside bit positions already collected. Only completed words are observable.
- Inputs sampled while reset=1 are ignored.

Decomposition:
- Shared package serial_pkg holds:
  - Bit-order constant BIT_ORDER_MSB=1'b1, BIT_ORDER_LSB=1'b0, shared with the shifter's right_left convention.
  - Default word width constant SER_WIDTH=8.
- One natural sub-module: word_hold_stage, the WIDTH-bit output register with valid/ready, load-on-complete and overrun generation.
- The top level contains the shift register, bit counter and order latch.

Test Plan:
- MSB-first: WIDTH=8, msb_first=1, bits 1,0,1,1,0,0,1,0 on consecutive cycles, word_ready=1 -> word_valid pulses one cycle, word_data=0xB2, the cycle after the 8th bit.
- LSB-first: same bit sequence with msb_first=0 -> word_data=0x4D. Toggling msb_first after the first bit leaves the result at 0x4D.
- Backpressure and overrun: word_ready=0, stream 16 bits 0xA5 then 0x3C (MSB-first) -> word_data holds 0xA5, overrun=1. Raise word_ready -> 0xA5 transferred, word_valid=0. Pulse clr_overrun -> overrun=0.
- Simultaneous transfer and completion: word_ready asserted on the cycle the second word completes -> word_data=second word, word_valid stays 1, overrun=0.
- Realignment: 3 bits, then sync_clear with no bit_valid -> bit_count=0; next 8 bits 0xFF -> word_data=0xFF. Repeat with sync_clear+bit_valid on the same cycle -> bit_count=1.
- Reset mid-word: assert reset at bit_count=5 with word_valid=1 and overrun=1 -> all outputs 0 next cycle. A following clean 8-bit word 0x81 completes correctly.

Source files
------------

// File: rtl/serial_pkg.sv
// Constants shared by the serial shifter / collector datapath.
// Bit-order encoding matches the shifter's right_left convention.
package serial_pkg;

    localparam logic BIT_ORDER_MSB = 1'b1;
    localparam logic BIT_ORDER_LSB = 1'b0;

    localparam int unsigned SER_WIDTH = 8;

endpackage

// File: rtl/word_hold_stage.sv
// Single-entry output register with valid/ready handoff and sticky overrun.
// A completion arriving while a word is held and not being taken is dropped.
module word_hold_stage
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = SER_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    input  logic             clr_overrun,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             overrun
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             drop;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        drop    = load & valid_q & ~ready;
        if (load && !drop) begin
            data_d  = load_data;
            valid_d = 1'b1;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
        // A new drop outranks a concurrent clear.
        overrun_d = drop | (overrun_q & ~clr_overrun);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign data    = data_q;
    assign valid   = valid_q;
    assign overrun = overrun_q;

endmodule

// File: rtl/serial_word_collector.sv
// Assembles WIDTH-bit words from a strobed serial stream, MSB- or LSB-first,
// and passes each completed word to a valid/ready holding stage.
module serial_word_collector
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = SER_WIDTH,
    parameter int unsigned CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             msb_first,
    input  logic             sync_clear,
    input  logic             word_ready,
    input  logic             clr_overrun,
    output logic [WIDTH-1:0] word_data,
    output logic             word_valid,
    output logic             overrun,
    output logic [CW-1:0]    bit_count
);

    localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CntOne  = CW'(1);

    logic [WIDTH-1:0] sh_q, sh_d, shifted;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             order_q, order_d, order_eff;
    logic             complete;

    always_comb begin
        // Order is taken fresh at the start of a word or on realignment.
        order_eff = (cnt_q == '0 || sync_clear) ? msb_first : order_q;
        shifted   = (order_eff == BIT_ORDER_MSB) ? {sh_q[WIDTH-2:0], bit_in}
                                                 : {bit_in, sh_q[WIDTH-1:1]};
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        order_d   = order_q;
        complete  = 1'b0;
        if (bit_valid) begin
            sh_d    = shifted;
            order_d = order_eff;
            if (sync_clear) begin
                cnt_d = CntOne;
            end else if (cnt_q == CntLast) begin
                cnt_d    = '0;
                complete = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (sync_clear) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_q    <= '0;
            cnt_q   <= '0;
            order_q <= 1'b0;
        end else begin
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            order_q <= order_d;
        end
    end

    word_hold_stage #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk         (clk),
        .reset       (reset),
        .load        (complete),
        .load_data   (shifted),
        .ready       (word_ready),
        .clr_overrun (clr_overrun),
        .data        (word_data),
        .valid       (word_valid),
        .overrun     (overrun)
    );

    assign bit_count = cnt_q;

endmodule
